// File: rtl/spi_host_initiator.sv
// rtl/spi_host_initiator.sv - host-side SPI master: status byte plus 16-bit word frames
module spi_host_initiator #(
    parameter int CLK_DIV = 4,
    parameter int NW_BITS = 10,
    parameter int CS_GAP  = 8
) (
    input  logic               hb_clk,
    input  logic               ha_rst,
    input  logic               start,
    input  logic               mode,
    input  logic [NW_BITS-1:0] nwords,
    input  logic [15:0]        tx_data,
    output logic               tx_rd,
    output logic [15:0]        rx_data,
    output logic               rx_valid,
    output logic [7:0]         status,
    output logic               nak,
    output logic               ovfl,
    output logic               busy,
    output logic               done,
    output logic               spi_sclk,
    output logic [1:0]         spi_cs,
    output logic               spi_mosi,
    input  logic               spi_miso
);

    // Bit counter is wide enough that 32 + 16*max_nwords never wraps.
    localparam int BC_W  = 16 + NW_BITS + 1;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [BC_W-1:0]   bit_q, bit_d;
    logic [BC_W-1:0]   last_q, last_d;
    logic [BC_W-1:0]   txend_q, txend_d;
    logic              ld_q, ld_d;
    logic [14:0]       sh_q, sh_d;
    logic [15:0]       nxt_q, nxt_d;
    logic [14:0]       rxsh_q, rxsh_d;
    logic              tx_rd_q, tx_rd_d;
    logic [15:0]       rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [7:0]        status_q, status_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic [1:0]        cs_q, cs_d;
    logic              mosi_q, mosi_d;

    logic              div_end;
    logic [BC_W-1:0]   bit_nx;

    assign div_end = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign bit_nx  = bit_q + BC_W'(1);

    // Next-state and output decode; every output leaves through a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        last_d     = last_q;
        txend_d    = txend_q;
        ld_d       = tx_rd_q;
        sh_d       = sh_q;
        nxt_d      = nxt_q;
        rxsh_d     = rxsh_q;
        tx_rd_d    = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        status_d   = status_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;

        // tx_data is valid the cycle after a tx_rd pulse
        if (ld_q) begin
            nxt_d = tx_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cs_d    = mode ? 2'b11 : 2'b01;
                    busy_d  = 1'b1;
                    txend_d = BC_W'({nwords, 4'b0000});
                    last_d  = BC_W'({nwords, 4'b0000}) + BC_W'(31);
                    tx_rd_d = (nwords != '0);
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = 1'b0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                // word 0 arrives during setup and goes straight onto MOSI
                if (ld_q) begin
                    sh_d   = tx_data[14:0];
                    mosi_d = tx_data[15];
                end
                if (div_end) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (!phase_q) begin
                    if (div_end) begin
                        sclk_d  = 1'b1;
                        phase_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (!div_end) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    // last high cycle: sample MISO, drop sclk, advance MOSI
                    rxsh_d = {rxsh_q[13:0], spi_miso};
                    if (bit_q == BC_W'(7)) begin
                        status_d = {rxsh_q[6:0], spi_miso};
                    end
                    if (bit_q >= BC_W'(32) && bit_q[3:0] == 4'hF) begin
                        rx_data_d  = {rxsh_q[14:0], spi_miso};
                        rx_valid_d = 1'b1;
                    end
                    sclk_d  = 1'b0;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    if (bit_q == last_q) begin
                        mosi_d  = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_nx;
                        if (bit_nx < txend_q) begin
                            if (bit_nx[3:0] == 4'h0) begin
                                sh_d   = nxt_q[14:0];
                                mosi_d = nxt_q[15];
                            end else begin
                                sh_d   = {sh_q[13:0], 1'b0};
                                mosi_d = sh_q[14];
                            end
                        end else begin
                            mosi_d = 1'b0;
                        end
                        // entering a word's last bit with another word to follow
                        if (bit_nx[3:0] == 4'hF && (bit_nx + BC_W'(1)) < txend_q) begin
                            tx_rd_d = 1'b1;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (div_end) begin
                    cs_d    = 2'b00;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the frame immediately with no done.
    always_ff @(posedge hb_clk or posedge ha_rst) begin
        if (ha_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            bit_q      <= '0;
            last_q     <= '0;
            txend_q    <= '0;
            ld_q       <= 1'b0;
            sh_q       <= '0;
            nxt_q      <= '0;
            rxsh_q     <= '0;
            tx_rd_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            status_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= 2'b00;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            txend_q    <= txend_d;
            ld_q       <= ld_d;
            sh_q       <= sh_d;
            nxt_q      <= nxt_d;
            rxsh_q     <= rxsh_d;
            tx_rd_q    <= tx_rd_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            status_q   <= status_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
        end
    end

    assign tx_rd    = tx_rd_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign status   = status_q;
    assign nak      = status_q[4];
    assign ovfl     = status_q[3];
    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_sclk = sclk_q;
    assign spi_cs   = cs_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_host_initiator.sv
// tb/tb_spi_host_initiator.sv - directed self-checking bench for spi_host_initiator
module tb_spi_host_initiator;

    logic        hb_clk = 1'b0;
    logic        ha_rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        sel = 1'b0;
    logic [9:0]  nwords = '0;
    logic [15:0] tx_data = '0;
    logic        spi_miso = 1'b0;

    always #5 hb_clk = ~hb_clk;

    logic        start4, start2;
    logic        tx_rd4, rx_valid4, busy4, done4, sclk4, mosi4, nak4, ovfl4;
    logic        tx_rd2, rx_valid2, busy2, done2, sclk2, mosi2, nak2, ovfl2;
    logic [15:0] rx_data4, rx_data2;
    logic [7:0]  status4, status2;
    logic [1:0]  cs4, cs2;

    assign start4 = start & ~sel;
    assign start2 = start & sel;

    spi_host_initiator #(.CLK_DIV(4), .NW_BITS(10), .CS_GAP(8)) u_dut4 (
        .hb_clk(hb_clk), .ha_rst(ha_rst), .start(start4), .mode(mode), .nwords(nwords),
        .tx_data(tx_data), .tx_rd(tx_rd4), .rx_data(rx_data4), .rx_valid(rx_valid4),
        .status(status4), .nak(nak4), .ovfl(ovfl4), .busy(busy4), .done(done4),
        .spi_sclk(sclk4), .spi_cs(cs4), .spi_mosi(mosi4), .spi_miso(spi_miso)
    );

    spi_host_initiator #(.CLK_DIV(2), .NW_BITS(10), .CS_GAP(8)) u_dut2 (
        .hb_clk(hb_clk), .ha_rst(ha_rst), .start(start2), .mode(mode), .nwords(nwords),
        .tx_data(tx_data), .tx_rd(tx_rd2), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .status(status2), .nak(nak2), .ovfl(ovfl2), .busy(busy2), .done(done2),
        .spi_sclk(sclk2), .spi_cs(cs2), .spi_mosi(mosi2), .spi_miso(spi_miso)
    );

    logic        m_sclk, m_mosi, m_tx_rd, m_rx_valid, m_done, m_busy, m_nak, m_ovfl;
    logic [1:0]  m_cs;
    logic [15:0] m_rx_data;
    logic [7:0]  m_status;

    assign m_sclk     = sel ? sclk2     : sclk4;
    assign m_mosi     = sel ? mosi2     : mosi4;
    assign m_tx_rd    = sel ? tx_rd2    : tx_rd4;
    assign m_rx_valid = sel ? rx_valid2 : rx_valid4;
    assign m_rx_data  = sel ? rx_data2  : rx_data4;
    assign m_done     = sel ? done2     : done4;
    assign m_busy     = sel ? busy2     : busy4;
    assign m_nak      = sel ? nak2      : nak4;
    assign m_ovfl     = sel ? ovfl2     : ovfl4;
    assign m_status   = sel ? status2   : status4;
    assign m_cs       = sel ? cs2       : cs4;

    int n_checks = 0;
    int n_fail = 0;

    logic         clr = 1'b0;
    logic         strict = 1'b0;
    logic [1:0]   exp_cs = 2'b01;
    logic [15:0]  tx_list [4];
    logic [127:0] slv_frame = '0;

    int rises = 0, txrd_cnt = 0, rx_cnt = 0, done_cnt = 0, cs_bad = 0;
    int hi_bad = 0, lo_bad = 0, min_stab = 99, frames = 0, last_gap = 0;
    int zero_run = 0, tx_ptr = 0, idx = 0, hi_run = 0, lo_run = 0, stab = 0;
    logic [15:0]  rx_got [4];
    logic [127:0] mosi_log = '1;
    logic         prev_sclk = 1'b0, prev_mosi = 1'b0, seen_rise = 1'b0, bitv;
    logic [1:0]   prev_cs = 2'b00;

    // Bus monitor and slave model, evaluated mid-cycle away from the DUT's clock edge.
    always @(negedge hb_clk) begin
        if (clr) begin
            rises = 0; txrd_cnt = 0; rx_cnt = 0; done_cnt = 0; cs_bad = 0;
            hi_bad = 0; lo_bad = 0; min_stab = 99; frames = 0; tx_ptr = 0;
            mosi_log = '1;
        end
        stab = (m_mosi == prev_mosi) ? stab + 1 : 1;
        if (m_sclk && !prev_sclk) begin
            rises++;
            mosi_log = {mosi_log[126:0], m_mosi};
            if (seen_rise && lo_run != (sel ? 2 : 4)) lo_bad++;
            if (stab < min_stab) min_stab = stab;
            seen_rise = 1'b1;
        end
        if (!m_sclk && prev_sclk && hi_run != (sel ? 2 : 4)) hi_bad++;
        if (m_sclk) hi_run = prev_sclk ? hi_run + 1 : 1;
        else        lo_run = prev_sclk ? 1 : lo_run + 1;
        if (m_cs == 2'b00) seen_rise = 1'b0;

        if (m_tx_rd) begin
            if (tx_ptr < 4) tx_data = tx_list[tx_ptr];
            tx_ptr++;
            txrd_cnt++;
        end
        if (m_rx_valid) begin
            if (rx_cnt < 4) rx_got[rx_cnt] = m_rx_data;
            rx_cnt++;
        end
        if (m_done) done_cnt++;
        if (m_cs != 2'b00 && m_cs != exp_cs) cs_bad++;
        if (m_cs != 2'b00 && prev_cs == 2'b00) begin
            frames++;
            last_gap = zero_run;
        end
        zero_run = (m_cs == 2'b00) ? zero_run + 1 : 0;

        // slave shifts on sclk falling; strict mode leaves the bit valid only in the last high cycle
        if (m_cs == 2'b00) idx = 0;
        else if (!m_sclk && prev_sclk && idx < 127) idx++;
        bitv = slv_frame[7'(127 - idx)];
        spi_miso = strict ? ((m_sclk && hi_run == 2) ? bitv : ~bitv) : bitv;

        prev_sclk = m_sclk;
        prev_mosi = m_mosi;
        prev_cs   = m_cs;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge hb_clk);
        clr = 1'b1;
        @(posedge hb_clk);
        clr = 1'b0;
    endtask

    task automatic pulse_start(input logic md, input logic [9:0] nw);
        @(negedge hb_clk);
        start = 1'b1;
        mode = md;
        nwords = nw;
        @(negedge hb_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        bit seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge hb_clk);
            seen = m_done;
        end
        chk(tag, seen, 1);
        repeat (3) @(negedge hb_clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge hb_clk);
        ha_rst = 1'b0;
        @(negedge hb_clk);
        chk("rst_cs", cs4, 2'b00);
        chk("rst_sclk_mosi", {sclk4, mosi4}, 2'b00);
        chk("rst_strobes", {tx_rd4, rx_valid4, done4, busy4}, 4'b0000);
        chk("rst_status", {status4, nak4, ovfl4}, 10'h000);
        chk("rst_rx_data", rx_data4, 16'h0000);

        // Frame 1: HOST, two words. Status 0x90 has bit 4 set, so nak is expected high.
        sel = 1'b0; strict = 1'b0; exp_cs = 2'b01;
        tx_list[0] = 16'hA55A; tx_list[1] = 16'h0F0F; tx_list[2] = 16'h0; tx_list[3] = 16'h0;
        slv_frame = {8'h90, 24'hA5C3FF, 16'h1234, 16'h5678, 64'h0};
        clear_mon();
        pulse_start(1'b0, 10'd2);
        wait_done("t1_done", 3000);
        chk("t1_rises", rises, 64);
        chk("t1_cs", {cs_bad, frames}, {32'd0, 32'd1});
        chk("t1_mosi", mosi_log[63:0], 64'hA55A0F0F00000000);
        chk("t1_txrd", txrd_cnt, 2);
        chk("t1_rx_cnt", rx_cnt, 2);
        chk("t1_rx0", rx_got[0], 16'h1234);
        chk("t1_rx1", rx_got[1], 16'h5678);
        chk("t1_status", m_status, 8'h90);
        chk("t1_nak_ovfl", {m_nak, m_ovfl}, 2'b10);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_phases", {hi_bad, lo_bad}, 64'd0);
        chk("t1_busy_after", m_busy, 1'b0);

        // Frame 2: status-only frame, slave reports nak and overflow.
        slv_frame = {8'h98, 24'hFFFFFF, 96'h0};
        clear_mon();
        pulse_start(1'b0, 10'd0);
        wait_done("t2_done", 2000);
        chk("t2_rises", rises, 32);
        chk("t2_status", m_status, 8'h98);
        chk("t2_nak_ovfl", {m_nak, m_ovfl}, 2'b11);
        chk("t2_rx_cnt", rx_cnt, 0);
        chk("t2_txrd", txrd_cnt, 0);
        chk("t2_mosi", mosi_log[31:0], 32'h0);

        // Frame 3: BOOT mode, three words.
        exp_cs = 2'b11;
        tx_list[0] = 16'hBEEF; tx_list[1] = 16'h1357; tx_list[2] = 16'h2468;
        slv_frame = {8'h80, 24'h000000, 16'hCAFE, 16'h0001, 16'h8000, 48'h0};
        clear_mon();
        pulse_start(1'b1, 10'd3);
        wait_done("t3_done", 3000);
        chk("t3_rises", rises, 80);
        chk("t3_cs", {cs_bad, frames}, {32'd0, 32'd1});
        chk("t3_txrd", txrd_cnt, 3);
        chk("t3_mosi", mosi_log[79:0], 80'hBEEF135724680000_0000);
        chk("t3_rx", {rx_got[0], rx_got[1], rx_got[2]}, {16'hCAFE, 16'h0001, 16'h8000});
        chk("t3_status", {m_status, m_nak, m_ovfl}, {8'h80, 2'b00});

        // Reset in the middle of the shift phase, then a clean frame.
        exp_cs = 2'b01;
        tx_list[0] = 16'hA55A; tx_list[1] = 16'h0F0F;
        slv_frame = {8'h90, 24'hA5C3FF, 16'h1234, 16'h5678, 64'h0};
        clear_mon();
        pulse_start(1'b0, 10'd2);
        for (int k = 0; k < 2000 && rises < 20; k++) @(negedge hb_clk);
        chk("rst_reached_bit20", rises >= 20, 1'b1);
        ha_rst = 1'b1;
        #1;
        chk("rst_mid_cs", cs4, 2'b00);
        chk("rst_mid_sclk_busy", {sclk4, busy4}, 2'b00);
        repeat (2) @(negedge hb_clk);
        ha_rst = 1'b0;
        repeat (30) @(negedge hb_clk);
        chk("rst_no_done", done_cnt, 0);
        clear_mon();
        pulse_start(1'b0, 10'd2);
        wait_done("rst_next_done", 3000);
        chk("rst_next_rises", rises, 64);
        chk("rst_next_rx", {rx_cnt, 16'(rx_got[0]), 16'(rx_got[1])}, {32'd2, 16'h1234, 16'h5678});

        // Start while busy is dropped; start on the done cycle is taken after a full gap.
        slv_frame = {8'h80, 120'h0};
        clear_mon();
        pulse_start(1'b0, 10'd0);
        repeat (20) @(negedge hb_clk);
        chk("bz_busy", m_busy, 1'b1);
        start = 1'b1;
        @(negedge hb_clk);
        start = 1'b0;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 2000 && !seen; k++) begin
                @(negedge hb_clk);
                seen = m_done;
            end
            chk("bz_first_done", seen, 1'b1);
            start = 1'b1;
            @(negedge hb_clk);
            start = 1'b0;
        end
        wait_done("bz_second_done", 2000);
        repeat (60) @(negedge hb_clk);
        chk("bz_frames", frames, 2);
        chk("bz_done_cnt", done_cnt, 2);
        chk("bz_gap_min", last_gap >= 8, 1'b1);
        chk("bz_rises", rises, 64);
        chk("bz_idle", m_busy, 1'b0);

        // CLK_DIV=2 instance: MISO is valid only in the last high cycle of each bit.
        sel = 1'b1; strict = 1'b1; exp_cs = 2'b01;
        tx_list[0] = 16'h5A3C;
        slv_frame = {8'h88, 24'h123456, 16'h9ABC, 80'h0};
        clear_mon();
        pulse_start(1'b0, 10'd1);
        wait_done("tm_done", 2000);
        chk("tm_rises", rises, 48);
        chk("tm_hi_phase", hi_bad, 0);
        chk("tm_lo_phase", lo_bad, 0);
        chk("tm_mosi_setup", min_stab >= 3, 1'b1);
        chk("tm_mosi", mosi_log[47:0], 48'h5A3C00000000);
        chk("tm_status", {m_status, m_nak, m_ovfl}, {8'h88, 2'b01});
        chk("tm_rx", {rx_cnt, 16'(rx_got[0])}, {32'd1, 16'h9ABC});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
